// File: rtl/i2c_slave_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_slave_regs: I2C target exposing DEPTH 8-bit registers.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2c_slave_regs #(
  parameter logic [6:0] I2C_ADR     = 7'h10,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         AUTO_INC    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] DEV_ADR = 4'd1;
  localparam logic [3:0] DEV_ACK = 4'd2;
  localparam logic [3:0] REG_ADR = 4'd3;
  localparam logic [3:0] REG_ACK = 4'd4;
  localparam logic [3:0] WR_DATA = 4'd5;
  localparam logic [3:0] WR_ACK  = 4'd6;
  localparam logic [3:0] RD_DATA = 4'd7;
  localparam logic [3:0] RD_ACK  = 4'd8;

  localparam logic [8:0] C_DEPTH = 9'(DEPTH);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, bus_start, bus_stop;

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_stb_q, wr_stb_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       fall_q;
  logic       done_q, done_d;
  logic       mem_we;

  logic [7:0] regs_q [DEPTH];
  logic [7:0] mem_view [256];
  logic [7:0] ptr_inc, rd_cur, rd_next;
  logic       ptr_ok, sr_ok, bit_in, byte_end, ack_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  assign bus_start = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign bus_stop  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

  // Out-of-range locations read as 8'hFF, so one 8-bit index covers all cases.
  for (genvar gi = 0; gi < 256; gi++) begin : g_mem
    if (gi < DEPTH) begin : g_reg
      assign mem_view[gi] = regs_q[gi];
    end else begin : g_pad
      assign mem_view[gi] = 8'hFF;
    end
  end

  assign host_rdata = mem_view[host_addr];
  assign ptr_inc    = (AUTO_INC != 0) ? ptr_q + 8'd1 : ptr_q;
  assign rd_cur     = mem_view[ptr_q];
  assign rd_next    = mem_view[ptr_inc];
  assign ptr_ok     = {1'b0, ptr_q} < C_DEPTH;
  assign sr_ok      = {1'b0, sr_q} < C_DEPTH;
  assign bit_in     = scl_rise && (cnt_q != 4'd8);
  // fall_q marks the clk after a detected SCL fall: the only point SDA may move.
  assign byte_end   = fall_q && (cnt_q == 4'd8);
  assign ack_end    = fall_q && (cnt_q == 4'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    if (bus_start) begin
      state_d  = DEV_ADR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (bus_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        DEV_ADR, REG_ADR, WR_DATA: begin
          if (bit_in) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            done_d = (state_q == WR_DATA) && (cnt_q == 4'd7);
          end
          if (done_q && ptr_ok) begin
            mem_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sr_q;
          end
          if (byte_end) begin
            cnt_d = 4'd0;
            if (state_q == DEV_ADR) begin
              if (sr_q[7:1] == I2C_ADR) begin
                state_d  = DEV_ACK;
                sda_oe_d = 1'b1;
                rw_d     = sr_q[0];
                busy_d   = 1'b1;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else if (state_q == REG_ADR) begin
              ptr_d    = sr_q;
              nack_d   = ~sr_ok;
              sda_oe_d = sr_ok;
              state_d  = REG_ACK;
            end else begin
              nack_d   = ~ptr_ok;
              sda_oe_d = ptr_ok;
              state_d  = WR_ACK;
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK, RD_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
            sr_d  = {sr_q[6:0], sda_s};
          end
          if (ack_end) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            if (state_q == DEV_ACK) begin
              if (rw_q) begin
                state_d  = RD_DATA;
                tx_d     = rd_cur;
                sda_oe_d = ~rd_cur[7];
              end else begin
                state_d = REG_ADR;
              end
            end else if (state_q == RD_ACK) begin
              if (!sr_q[0]) begin
                ptr_d    = ptr_inc;
                tx_d     = rd_next;
                sda_oe_d = ~rd_next[7];
                state_d  = RD_DATA;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else if (nack_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              if (state_q == WR_ACK) ptr_d = ptr_inc;
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (bit_in) cnt_d = cnt_q + 4'd1;
          if (fall_q && (cnt_q != 4'd0) && (cnt_q != 4'd8))
            sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
          if (byte_end) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      tx_q      <= 8'h00;
      ptr_q     <= 8'h00;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      fall_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fall_q    <= scl_fall;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mem_we && (ptr_q == 8'(i))) regs_q[i] <= sr_q;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_i2c_slave_regs: directed bus-master bench for i2c_slave_regs.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_i2c_slave_regs;

  localparam int Q = 80;

  logic       clk, rst, scl_m, sda_m;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] wr_addr, wr_data, host_addr, host_rdata;
  wire        sda_bus = sda_m & ~sda_oe;

  int         n_vec, n_bad, n_stb, oe_cnt, busy_cnt, viol;
  logic [7:0] cap_a, cap_d;
  logic       prev_oe;

  i2c_slave_regs #(
    .I2C_ADR(7'h10), .DEPTH(16), .SYNC_STAGES(2), .AUTO_INC(1)
  ) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    n_stb = 0; oe_cnt = 0; busy_cnt = 0; viol = 0; prev_oe = 1'b0;
    cap_a = 8'h00; cap_d = 8'h00;
  end

  always @(negedge clk) begin
    if (wr_stb) begin
      n_stb++;
      cap_a = wr_addr;
      cap_d = wr_data;
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (!rst && scl_m && (sda_oe !== prev_oe)) viol++;
    prev_oe = sda_oe;
  end

  task automatic i2c_start;
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = ~sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1; #Q; b = {b[6:0], sda_bus}; #Q; scl_m = 1'b0;
    end
    sda_m = mack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0", wr_stb); end
    n_vec++; if (wr_addr !== 8'h00) begin n_bad++; $display("FAIL rst_waddr: got %h want 00", wr_addr); end
    n_vec++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %h want 00", wr_data); end
    host_addr = 8'h03; #1;
    n_vec++; if (host_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_reg3: got %h want 00", host_rdata); end
    host_addr = 8'h20; #1;
    n_vec++; if (host_rdata !== 8'hFF) begin n_bad++; $display("FAIL rst_oob: got %h want FF", host_rdata); end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    logic a1, a2, a3;
    int   n0;
    @(negedge clk);
    n0 = n_stb;
    i2c_start;
    send_byte(8'h20, a1);
    send_byte(8'h03, a2);
    send_byte(8'hA5, a3);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2, a3} !== 3'b111) begin n_bad++; $display("FAIL wr_acks: got %b want 111", {a1, a2, a3}); end
    n_vec++; if (n_stb - n0 !== 1) begin n_bad++; $display("FAIL wr_stb_count: got %0d want 1", n_stb - n0); end
    n_vec++; if (cap_a !== 8'h03) begin n_bad++; $display("FAIL wr_addr: got %h want 03", cap_a); end
    n_vec++; if (cap_d !== 8'hA5) begin n_bad++; $display("FAIL wr_data: got %h want A5", cap_d); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    host_addr = 8'h03; #1;
    n_vec++; if (host_rdata !== 8'hA5) begin n_bad++; $display("FAIL wr_host: got %h want A5", host_rdata); end
  endtask

  task automatic test_write_read;
    logic       a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] d0, d1;
    @(negedge clk);
    i2c_start;
    send_byte(8'h20, a1); send_byte(8'h05, a2); send_byte(8'h11, a3); send_byte(8'h22, a4);
    i2c_stop;
    i2c_start;
    send_byte(8'h20, a5); send_byte(8'h05, a6);
    i2c_start;
    send_byte(8'h21, a7);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2, a3, a4, a5, a6, a7} !== 7'h7F) begin n_bad++; $display("FAIL wrd_acks: got %b want 1111111", {a1, a2, a3, a4, a5, a6, a7}); end
    n_vec++; if (d0 !== 8'h11) begin n_bad++; $display("FAIL wrd_byte0: got %h want 11", d0); end
    n_vec++; if (d1 !== 8'h22) begin n_bad++; $display("FAIL wrd_byte1: got %h want 22", d1); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrd_idle_after_nack: busy got %b want 0", busy); end
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_bad_addr;
    logic a1, a2;
    int   o0, b0;
    @(negedge clk);
    o0 = oe_cnt; b0 = busy_cnt;
    i2c_start;
    send_byte(8'h40, a1);
    send_byte(8'h03, a2);
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2} !== 2'b00) begin n_bad++; $display("FAIL bad_acks: got %b want 00", {a1, a2}); end
    n_vec++; if (oe_cnt - o0 !== 0) begin n_bad++; $display("FAIL bad_oe: got %0d driven clks want 0", oe_cnt - o0); end
    n_vec++; if (busy_cnt - b0 !== 0) begin n_bad++; $display("FAIL bad_busy: got %0d busy clks want 0", busy_cnt - b0); end
  endtask

  task automatic test_reg_range;
    logic       a1, a2, a3, a4;
    logic [7:0] d0;
    int         n0, o0;
    @(negedge clk);
    n0 = n_stb;
    i2c_start;
    send_byte(8'h20, a1); send_byte(8'h10, a2); send_byte(8'h55, a3);
    i2c_stop;
    i2c_start;
    send_byte(8'h21, a4);
    o0 = oe_cnt;
    recv_byte(1'b1, d0);
    n_vec++; if (oe_cnt - o0 !== 0) begin n_bad++; $display("FAIL rng_read_oe: got %0d driven clks want 0", oe_cnt - o0); end
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2, a3, a4} !== 4'b1001) begin n_bad++; $display("FAIL rng_acks: got %b want 1001", {a1, a2, a3, a4}); end
    n_vec++; if (n_stb - n0 !== 0) begin n_bad++; $display("FAIL rng_stb: got %0d want 0", n_stb - n0); end
    n_vec++; if (d0 !== 8'hFF) begin n_bad++; $display("FAIL rng_read: got %h want FF", d0); end
  endtask

  task automatic test_boundary;
    logic       a1, a2, a3, a4, a5;
    logic [7:0] d0;
    int         n0;
    @(negedge clk);
    n0 = n_stb;
    i2c_start;
    send_byte(8'h20, a1); send_byte(8'h0F, a2); send_byte(8'h77, a3); send_byte(8'h88, a4);
    i2c_stop;
    i2c_start;
    send_byte(8'h21, a5);
    recv_byte(1'b1, d0);
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2, a3, a4, a5} !== 5'b11101) begin n_bad++; $display("FAIL bnd_acks: got %b want 11101", {a1, a2, a3, a4, a5}); end
    n_vec++; if (n_stb - n0 !== 1) begin n_bad++; $display("FAIL bnd_stb: got %0d want 1", n_stb - n0); end
    n_vec++; if (cap_d !== 8'h77) begin n_bad++; $display("FAIL bnd_wdata: got %h want 77", cap_d); end
    n_vec++; if (d0 !== 8'hFF) begin n_bad++; $display("FAIL bnd_ptr_read: got %h want FF", d0); end
    host_addr = 8'h0F; #1;
    n_vec++; if (host_rdata !== 8'h77) begin n_bad++; $display("FAIL bnd_reg15: got %h want 77", host_rdata); end
  endtask

  task automatic test_reset_midread;
    logic a1, a2, a3, a4, a5, a6;
    @(negedge clk);
    i2c_start;
    send_byte(8'h20, a1); send_byte(8'h00, a2);
    i2c_start;
    send_byte(8'h21, a3);
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0;
    end
    #Q; scl_m = 1'b1; #Q;
    n_vec++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL mid_oe_before: got %b want 1", sda_oe); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL mid_oe_reset: got %b want 0", sda_oe); end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    scl_m = 1'b0; #Q;
    i2c_stop;
    i2c_start;
    send_byte(8'h20, a4); send_byte(8'h02, a5); send_byte(8'h5A, a6);
    i2c_stop;
    repeat (4) @(negedge clk);
    n_vec++; if ({a1, a2, a3, a4, a5, a6} !== 6'h3F) begin n_bad++; $display("FAIL mid_acks: got %b want 111111", {a1, a2, a3, a4, a5, a6}); end
    host_addr = 8'h02; #1;
    n_vec++; if (host_rdata !== 8'h5A) begin n_bad++; $display("FAIL mid_reg2: got %h want 5A", host_rdata); end
    host_addr = 8'h05; #1;
    n_vec++; if (host_rdata !== 8'h00) begin n_bad++; $display("FAIL mid_reg5_cleared: got %h want 00", host_rdata); end
  endtask

  initial begin
    scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1; host_addr = 8'h00;
    n_vec = 0; n_bad = 0;
    test_reset;
    test_write;
    test_write_read;
    test_bad_addr;
    test_reg_range;
    test_boundary;
    test_reset_midread;
    n_vec++; if (viol !== 0) begin n_bad++; $display("FAIL oe_while_scl_high: got %0d changes want 0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter I2C_ADR, default 7'h10: 7-bit device address answered on the bus.
REQ-002 Parameter DEPTH, default 16, range 1..256: number of 8-bit registers.
REQ-003 Parameter SYNC_STAGES, default 2, range 2..4: synchroniser flops on scl_i and sda_i.
REQ-004 Parameter AUTO_INC, default 1: when 1, the register pointer increments after each data byte; when 0, it holds.
REQ-005 clk  input  1  system clock, at least 16x the SCL rate; the block uses this one clock only.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 scl_i  input  1  bus SCL level, asynchronous.
REQ-008 sda_i  input  1  bus SDA level, asynchronous.
REQ-009 sda_oe  output  1  1 = pull SDA low; 0 = release SDA to Z (the top level ties the pin to 0 when enabled).
REQ-010 wr_stb  output  1  one-clk pulse when a bus write has been stored.
REQ-011 wr_addr  output  8  register address of the last stored write.
REQ-012 wr_data  output  8  data byte of the last stored write.
REQ-013 busy  output  1  high from an addressed START until STOP or NACK-to-idle.
REQ-014 host_addr  input  8  local read-port address.
REQ-015 host_rdata  output  8  combinational read of register host_addr; 8'hFF when host_addr >= DEPTH.

Function
REQ-016 scl_i and sda_i SHALL pass through SYNC_STAGES flops; all decoding SHALL use the synchronised signals (scl_s, sda_s) and their one-clk-delayed copies.
REQ-017 START SHALL be detected when sda_s falls while scl_s is high, and STOP when sda_s rises while scl_s is high; each detection SHALL be a one-clk event.
REQ-018 Data bits SHALL be sampled on the clk in which an scl_s rising edge is detected, and shifted MSB first.
REQ-019 sda_oe SHALL change only one clk after an scl_s falling edge is detected, which gives SDA hold time after SCL falls.
REQ-020 The FSM SHALL have the states IDLE, DEV_ADR, DEV_ACK, REG_ADR, REG_ACK, WR_DATA, WR_ACK, RD_DATA and RD_ACK.
REQ-021 A START in any state SHALL move the FSM to DEV_ADR, clear the bit counter and release sda_oe; this covers the repeated-START case.
REQ-022 A STOP in any state SHALL move the FSM to IDLE, release sda_oe and clear busy.
REQ-023 DEV_ADR SHALL collect 8 bits. If bits[7:1] equal I2C_ADR, the block SHALL drive an ACK (sda_oe=1) for the 9th SCL period and enter DEV_ACK, latching rw = bit0. Otherwise it SHALL enter IDLE without driving.
REQ-024 From DEV_ACK the FSM SHALL go to REG_ADR when rw=0, and to RD_DATA when rw=1.
REQ-025 In RD_DATA, the first bit SHALL be driven on the SCL fall that ends the ACK.
REQ-026 REG_ADR SHALL collect 8 bits into the pointer. If the pointer is below DEPTH the block SHALL ACK; otherwise it SHALL NACK, and the FSM SHALL go to IDLE after the ACK slot.
REQ-027 WR_DATA SHALL collect 8 bits. If pointer < DEPTH the block SHALL store the byte, pulse wr_stb and update wr_addr/wr_data on the clk after the 8th sample, and ACK. Otherwise it SHALL not store, NACK, and go to IDLE.
REQ-028 After each WR_ACK the FSM SHALL return to WR_DATA, and the pointer SHALL increment when AUTO_INC=1.
REQ-029 RD_DATA SHALL shift out reg[pointer] MSB first, with sda_oe = ~bit.
REQ-030 A read from pointer >= DEPTH SHALL return 8'hFF, with the bus released throughout.
REQ-031 In RD_ACK the block SHALL release SDA and sample the master's bit. On ACK (0) the pointer SHALL increment when AUTO_INC=1, and the FSM SHALL load the next byte and return to RD_DATA. On NACK (1) the FSM SHALL go to IDLE.
REQ-032 Pointer increment SHALL be modulo 256, and the pointer SHALL persist across STOP/START so that a write-pointer, repeated-START, read sequence works.
REQ-033 wr_stb SHALL never assert outside WR_DATA-to-WR_ACK.
REQ-034 sda_oe SHALL never assert while scl_s is high except during an ACK or data bit that was launched on the preceding SCL fall.

Reset
REQ-035 On rst=1 at a clk edge, the block SHALL set state=IDLE, sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, pointer=0, rw=0, bit counter=0, and preload the synchroniser flops to 1.
REQ-036 Register contents SHALL reset to 8'h00.
REQ-037 A reset asserted mid-transfer SHALL release SDA within the same clk edge; after rst deasserts, the block SHALL ignore bus activity until the next START.

Verification
REQ-038 START, 0x20 (addr 0x10, W), 0x03, 0xA5, STOP -> three ACKs; wr_stb pulses once with wr_addr=0x03 and wr_data=0xA5; host_addr=0x03 reads 0xA5.
REQ-039 Write at pointer 0x05 with data 0x11, 0x22, then repeated START, 0x21, read two bytes with master ACK then NACK -> read data 0x11, 0x22; FSM reaches IDLE after the NACK; busy=0 after STOP.
REQ-040 Address byte 0x40 (addr 0x20) -> no ACK, sda_oe stays 0 for the whole frame, busy stays 0.
REQ-041 DEPTH=16, register address 0x10 -> NACK on the register byte and no wr_stb; a subsequent read at pointer 0x10 returns 0xFF.
REQ-042 Write 0x0F with data 0x77, 0x88 (AUTO_INC=1) -> reg[15]=0x77; the second byte is NACKed and not stored; the pointer equals 0x10.
REQ-043 Assert rst during the 4th data bit of a read of 0x00 -> sda_oe=0 on the same edge; a following full write transaction completes with correct ACKs.
